// File: rtl/narrow_serializer.sv
// Narrows 32-bit register words onto a 16-bit beat bus: HALF mode emits one checked beat, WORD mode two beats (low first).
// Optional clamping of overflowing HALF beats is enabled by defining NARROW_SAT_EN.
module narrow_serializer #(
    parameter int DIN_W  = 32,  // must equal 2*DOUT_W
    parameter int DOUT_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DIN_W-1:0]  data_i,
    input  logic              mode_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DOUT_W-1:0] data_o,
    output logic              last_o,
    output logic              ovf_o,
    output logic [CNT_W-1:0]  ovf_cnt_o,
    input  logic              cnt_clr_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_e;

    localparam logic MODE_HALF = 1'b0;

    state_e              state_q, state_d;
    logic [DIN_W-1:0]    word_q, word_d;
    logic                mode_q, mode_d;
    logic [DOUT_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                word_ovf;
    logic [DOUT_W-1:0]   lo_beat;
    logic                accept;
    logic                out_hs;

    // Word survives re-sign-extension only if the upper half replicates bit 15.
    assign word_ovf = (word_q[DIN_W-1:DOUT_W] != {DOUT_W{word_q[DOUT_W-1]}});

`ifdef NARROW_SAT_EN
    always_comb begin
        lo_beat = word_q[DOUT_W-1:0];
        if (mode_q == MODE_HALF && word_ovf) begin
            lo_beat = word_q[DIN_W-1] ? {1'b1, {(DOUT_W-1){1'b0}}}
                                      : {1'b0, {(DOUT_W-1){1'b1}}};
        end
    end
`else
    assign lo_beat = word_q[DOUT_W-1:0];
`endif

    always_comb begin
        out_valid_o = 1'b0;
        last_o      = 1'b0;
        ovf_o       = 1'b0;
        data_o      = data_q;
        case (state_q)
            SEND_LO: begin
                out_valid_o = 1'b1;
                last_o      = (mode_q == MODE_HALF);
                ovf_o       = (mode_q == MODE_HALF) && word_ovf;
                data_o      = lo_beat;
            end
            SEND_HI: begin
                out_valid_o = 1'b1;
                last_o      = 1'b1;
                data_o      = word_q[DIN_W-1:DOUT_W];
            end
            default: ;
        endcase
    end

    assign out_hs     = out_valid_o & out_ready_i;
    assign in_ready_o = (state_q == IDLE) | (out_valid_o & last_o & out_ready_i);
    assign accept     = in_valid_i & in_ready_o;
    assign ovf_cnt_o  = cnt_q;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        mode_d  = mode_q;
        // data_q tracks the presented beat so IDLE keeps showing the last one.
        data_d  = data_o;
        if (accept) begin
            word_d = data_i;
            mode_d = mode_i;
        end
        case (state_q)
            IDLE: begin
                if (accept) state_d = SEND_LO;
            end
            SEND_LO: begin
                if (out_hs) begin
                    if (mode_q != MODE_HALF) state_d = SEND_HI;
                    else                     state_d = accept ? SEND_LO : IDLE;
                end
            end
            SEND_HI: begin
                if (out_hs) state_d = accept ? SEND_LO : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear wins over a coincident increment; increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (out_hs && ovf_o && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            word_q  <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_narrow_serializer.sv
// Scoreboard bench for narrow_serializer: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_narrow_serializer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] data_i;
    logic        mode_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] data_o;
    logic        last_o;
    logic        ovf_o;
    logic [7:0]  ovf_cnt_o;
    logic        cnt_clr_i;

    narrow_serializer #(.DIN_W(32), .DOUT_W(16), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .data_i(data_i), .mode_i(mode_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .data_o(data_o), .last_o(last_o), .ovf_o(ovf_o),
        .ovf_cnt_o(ovf_cnt_o), .cnt_clr_i(cnt_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic        ovf;
    } beat_t;

    beat_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    hs_cyc  = 0;
    int    hs_prev = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Handshake is decided by values stable at the falling edge.
    always @(negedge clk_i) begin
        if (rst_i && out_valid_o && out_ready_i) begin
            hs_prev = hs_cyc;
            hs_cyc  = cyc;
            if (sb.size() == 0) begin
                check("unexpected_beat", {16'h0, data_o}, 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("beat_data", {16'h0, data_o}, {16'h0, e.data});
                check("beat_last", {31'h0, last_o}, {31'h0, e.last});
                check("beat_ovf",  {31'h0, ovf_o},  {31'h0, e.ovf});
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic l, input logic o);
        beat_t b;
        b.data = d; b.last = l; b.ovf = o;
        sb.push_back(b);
    endtask

    // Presents one word and returns one step after the accepting edge.
    task automatic send(input logic [31:0] d, input logic m);
        int n = 0;
        in_valid_i = 1'b1;
        data_i     = d;
        mode_i     = m;
        #1;
        while (!in_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'd0, 32'd1);
        tick();
        in_valid_i = 1'b0;
        data_i     = 32'hA5A5_A5A5;
        mode_i     = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready_i = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

`ifdef NARROW_SAT_EN
    localparam logic [15:0] POS_OVF_2345 = 16'h7FFF;
    localparam logic [15:0] NEG_OVF_0000 = 16'h8000;
    localparam logic [15:0] POS_OVF_0000 = 16'h7FFF;
`else
    localparam logic [15:0] POS_OVF_2345 = 16'h2345;
    localparam logic [15:0] NEG_OVF_0000 = 16'h0000;
    localparam logic [15:0] POS_OVF_0000 = 16'h0000;
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; in_valid_i = 1'b0; data_i = '0; mode_i = 1'b0;
        out_ready_i = 1'b0; cnt_clr_i = 1'b0;
        tick(); tick();
        rst_i = 1'b1;
        #1;
        check("rst_out_valid", {31'h0, out_valid_o}, 32'd0);
        check("rst_data",      {16'h0, data_o},      32'd0);
        check("rst_last",      {31'h0, last_o},      32'd0);
        check("rst_ovf",       {31'h0, ovf_o},       32'd0);
        check("rst_cnt",       {24'h0, ovf_cnt_o},   32'd0);
        check("rst_in_ready",  {31'h0, in_ready_o},  32'd1);

        // HALF, sign-extendable
        out_ready_i = 1'b1;
        push(16'h8001, 1'b1, 1'b0);
        send(32'hFFFF_8001, 1'b0);
        drain(2);
        check("t1_cnt", {24'h0, ovf_cnt_o}, 32'd0);

        // HALF, positive and negative overflow
        push(POS_OVF_2345, 1'b1, 1'b1);
        send(32'h0001_2345, 1'b0);
        drain(2);
        check("t2_cnt", {24'h0, ovf_cnt_o}, 32'd1);
        push(NEG_OVF_0000, 1'b1, 1'b1);
        send(32'h8000_0000, 1'b0);
        drain(2);
        check("t2b_cnt", {24'h0, ovf_cnt_o}, 32'd2);

        // WORD with a stalled low beat
        out_ready_i = 1'b0;
        push(16'hBEEF, 1'b0, 1'b0);
        push(16'hDEAD, 1'b1, 1'b0);
        send(32'hDEAD_BEEF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_stall_valid", {31'h0, out_valid_o}, 32'd1);
            check("t3_stall_data",  {16'h0, data_o},      32'h0000_BEEF);
            check("t3_stall_last",  {31'h0, last_o},      32'd0);
            check("t3_stall_ready", {31'h0, in_ready_o},  32'd0);
            tick();
        end
        out_ready_i = 1'b1;
        #1;
        check("t3_lo_ready", {31'h0, in_ready_o}, 32'd0);
        tick();
        check("t3_hi_data",  {16'h0, data_o},     32'h0000_DEAD);
        check("t3_hi_last",  {31'h0, last_o},     32'd1);
        check("t3_hi_ready", {31'h0, in_ready_o}, 32'd1);
        drain(2);
        check("t3_cnt", {24'h0, ovf_cnt_o}, 32'd2);

        // back-to-back HALF words
        push(16'h0005, 1'b1, 1'b0);
        push(16'hFFFE, 1'b1, 1'b0);
        send(32'h0000_0005, 1'b0);
        send(32'hFFFF_FFFE, 1'b0);
        drain(2);
        check("t4_consecutive", hs_cyc - hs_prev, 32'd1);

        // saturate the overflow counter
        for (int i = 0; i < 300; i++) begin
            push(POS_OVF_0000 | ((POS_OVF_0000 == 16'h0) ? i[15:0] : 16'h0), 1'b1, 1'b1);
            send(32'h0001_0000 | {16'h0, 1'b0, i[14:0]}, 1'b0);
        end
        drain(3);
        check("t6_saturated", {24'h0, ovf_cnt_o}, 32'd255);

        // clear coinciding with an overflow handshake
        out_ready_i = 1'b0;
        push(POS_OVF_0000, 1'b1, 1'b1);
        send(32'h0001_0000, 1'b0);
        cnt_clr_i   = 1'b1;
        out_ready_i = 1'b1;
        #1;
        check("t6_pre_clear", {24'h0, ovf_cnt_o}, 32'd255);
        tick();
        cnt_clr_i = 1'b0;
        check("t6_clear_wins", {24'h0, ovf_cnt_o}, 32'd0);
        push(POS_OVF_2345, 1'b1, 1'b1);
        send(32'h0001_2345, 1'b0);
        drain(2);
        check("t6_after_clear", {24'h0, ovf_cnt_o}, 32'd1);

        // reset while the high beat is pending
        out_ready_i = 1'b1;
        push(16'h5678, 1'b0, 1'b0);
        push(16'h1234, 1'b1, 1'b0);
        send(32'h1234_5678, 1'b1);
        tick();
        out_ready_i = 1'b0;
        #1;
        check("t5_in_hi_valid", {31'h0, out_valid_o}, 32'd1);
        check("t5_pending",     sb.size(),            32'd1);
        rst_i = 1'b0;
        tick();
        check("t5_rst_valid", {31'h0, out_valid_o}, 32'd0);
        check("t5_rst_ready", {31'h0, in_ready_o},  32'd1);
        check("t5_rst_cnt",   {24'h0, ovf_cnt_o},   32'd0);
        sb.delete();
        rst_i = 1'b1;
        drain(4);
        check("t5_no_partial", {31'h0, out_valid_o}, 32'd0);
        check("sb_empty",      sb.size(),            32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
